// File: rtl/mul_seq_ctrl_if.sv
// Bus between the MIPS decoder/register file and the MUL sequencer.
//   start_i    : decoder flags the current instruction as MUL
//   rs_data_i  : multiplier operand (RF read port 1)
//   rt_data_i  : multiplicand operand (RF read port 2)
//   rd_addr_i  : destination register of the MUL
//   stall_o    : freeze PC and suppress the normal RF write
//   busy_o     : sequencer not idle
//   wb_en_o    : RF write enable for the MUL result
//   wb_addr_o  : RF write address for the MUL result
//   result_o   : RF write data (low DATA_W bits of the product)
//   done_o     : one-cycle completion pulse
// master = decoder/RF side, slave = sequencer.
interface mul_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [4:0]        rd_addr_i;
  logic              stall_o;
  logic              busy_o;
  logic              wb_en_o;
  logic [4:0]        wb_addr_o;
  logic [DATA_W-1:0] result_o;
  logic              done_o;

  modport master (
    output start_i, rs_data_i, rt_data_i, rd_addr_i,
    input  stall_o, busy_o, wb_en_o, wb_addr_o, result_o, done_o
  );

  modport slave (
    input  start_i, rs_data_i, rt_data_i, rd_addr_i,
    output stall_o, busy_o, wb_en_o, wb_addr_o, result_o, done_o
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer for the single-cycle MIPS core.
// Latches rs/rt/rd when the decoder flags a MUL, runs a shift-add multiply
// one bit per cycle while stalling the PC, then issues a single RF write of
// the low DATA_W product bits and releases the PC.
// Ports:
//   clk_i : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mul_seq_ctrl_if slave modport (handshake, operands, writeback)
// Parameters:
//   DATA_W     : operand/result width
//   EARLY_EXIT : 1 = stop once the remaining multiplier is zero,
//                0 = always run DATA_W iterations
module mul_seq_ctrl #(
  parameter int DATA_W     = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk_i,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [DATA_W-1:0] mplr;
  logic [DATA_W-1:0] mcnd;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        rd_q;

  logic [DATA_W-1:0] mplr_shr;
  logic              calc_last;

  assign mplr_shr = mplr >> 1;

  // Finish on the last bit position, or as soon as no multiplier bits remain.
  assign calc_last = (cnt == CNT_LAST) ||
                     ((EARLY_EXIT != 0) && (mplr_shr == '0));

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand / accumulator registers. Cleared on reset so an aborted MUL
  // leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mplr <= '0;
      mcnd <= '0;
      acc  <= '0;
      cnt  <= '0;
      rd_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            mplr <= bus.rs_data_i;
            mcnd <= bus.rt_data_i;
            rd_q <= bus.rd_addr_i;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          if (mplr[0]) begin
            acc <= acc + mcnd;
          end
          mcnd <= mcnd << 1;
          mplr <= mplr_shr;
          cnt  <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and outputs. stall_o depends on start_i combinationally so the
  // PC already holds at the edge closing the MUL's first cycle; it drops in WB
  // so the PC advances on the same edge that writes the RF.
  always_comb begin
    state_d       = state_q;
    bus.stall_o   = 1'b0;
    bus.busy_o    = 1'b0;
    bus.wb_en_o   = 1'b0;
    bus.wb_addr_o = '0;
    bus.result_o  = '0;
    bus.done_o    = 1'b0;

    case (state_q)
      IDLE: begin
        bus.stall_o = bus.start_i;
        if (bus.start_i) begin
          state_d = CALC;
        end
      end
      CALC: begin
        bus.stall_o = 1'b1;
        bus.busy_o  = 1'b1;
        if (calc_last) begin
          state_d = WB;
        end
      end
      WB: begin
        bus.busy_o    = 1'b1;
        bus.wb_en_o   = (rd_q != 5'd0);
        bus.wb_addr_o = rd_q;
        bus.result_o  = acc;
        bus.done_o    = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: one instance with EARLY_EXIT=1 (bus_e) and
// one with EARLY_EXIT=0 (bus_f) share clock, reset and operand inputs; a small
// register-file model captures writebacks from both.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rf_clr;
  logic        start;
  logic        use_f;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  mul_seq_ctrl_if #(.DATA_W(32)) bus_e ();
  mul_seq_ctrl_if #(.DATA_W(32)) bus_f ();

  assign bus_e.start_i   = start & ~use_f;
  assign bus_e.rs_data_i = rs;
  assign bus_e.rt_data_i = rt;
  assign bus_e.rd_addr_i = rd;
  assign bus_f.start_i   = start & use_f;
  assign bus_f.rs_data_i = rs;
  assign bus_f.rt_data_i = rt;
  assign bus_f.rd_addr_i = rd;

  mul_seq_ctrl #(.DATA_W(32), .EARLY_EXIT(1)) dut_e (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  mul_seq_ctrl #(.DATA_W(32), .EARLY_EXIT(0)) dut_f (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  wire        stall_s  = use_f ? bus_f.stall_o   : bus_e.stall_o;
  wire        busy_s   = use_f ? bus_f.busy_o    : bus_e.busy_o;
  wire        done_s   = use_f ? bus_f.done_o    : bus_e.done_o;
  wire        wben_s   = use_f ? bus_f.wb_en_o   : bus_e.wb_en_o;
  wire [4:0]  wbaddr_s = use_f ? bus_f.wb_addr_o : bus_e.wb_addr_o;
  wire [31:0] result_s = use_f ? bus_f.result_o  : bus_e.result_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : (32'hDEAD_0000 | i);
    end else begin
      if (bus_e.wb_en_o) rf[bus_e.wb_addr_o] <= bus_e.result_o;
      if (bus_f.wb_en_o) rf[bus_f.wb_addr_o] <= bus_f.result_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one MUL from its start cycle through WB. Inputs are driven 1 after
  // the edge, outputs sampled 2 after the edge. Returns after the WB edge.
  task automatic run_mul(input logic sel_f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic keep_start,
                         output int total, output int stall_n, output logic got,
                         output logic first_busy, output logic wb_stall,
                         output logic [31:0] res, output logic wbe, output logic [4:0] wba);
    use_f = sel_f;
    rs = a;
    rt = b;
    rd = d;
    start = 1'b1;
    total = 0;
    stall_n = 0;
    got = 1'b0;
    wb_stall = 1'b1;
    res = '0;
    wbe = 1'b0;
    wba = '0;
    #1;
    first_busy = busy_s;
    for (int i = 0; i < 100; i++) begin
      total++;
      if (stall_s) stall_n++;
      if (done_s) begin
        got = 1'b1;
        res = result_s;
        wbe = wben_s;
        wba = wbaddr_s;
        wb_stall = stall_s;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!keep_start) start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int          total;
  int          stall_n;
  logic        got;
  logic        first_busy;
  logic        wb_stall;
  logic [31:0] res;
  logic        wbe;
  logic [4:0]  wba;

  initial begin
    rst_n = 1'b0;
    rf_clr = 1'b1;
    start = 1'b0;
    use_f = 1'b0;
    rs = '0;
    rt = '0;
    rd = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall_e", {31'b0, bus_e.stall_o}, 32'd0);
    chk("rst_busy_e", {31'b0, bus_e.busy_o}, 32'd0);
    chk("rst_wben_e", {31'b0, bus_e.wb_en_o}, 32'd0);
    chk("rst_done_e", {31'b0, bus_e.done_o}, 32'd0);
    chk("rst_result_e", bus_e.result_o, 32'd0);
    chk("rst_wbaddr_e", {27'b0, bus_e.wb_addr_o}, 32'd0);
    chk("rst_busy_f", {31'b0, bus_f.busy_o}, 32'd0);
    chk("rst_result_f", bus_f.result_o, 32'd0);
    rst_n = 1'b1;
    rf_clr = 1'b0;
    @(posedge clk);
    #1;

    // 3 x 5 -> r8, early exit: 1 + 2 + 1 cycles, stall for 3.
    run_mul(1'b0, 32'd3, 32'd5, 5'd8, 1'b0, total, stall_n, got, first_busy, wb_stall, res, wbe, wba);
    chk("t1_done", {31'b0, got}, 32'd1);
    chk("t1_first_busy", {31'b0, first_busy}, 32'd0);
    chk("t1_total", total, 32'd4);
    chk("t1_stall_cycles", stall_n, 32'd3);
    chk("t1_wb_stall", {31'b0, wb_stall}, 32'd0);
    chk("t1_result", res, 32'd15);
    chk("t1_wben", {31'b0, wbe}, 32'd1);
    chk("t1_wbaddr", {27'b0, wba}, 32'd8);
    chk("t1_rf8", rf[8], 32'd15);
    chk("t1_idle_after", {31'b0, bus_e.busy_o}, 32'd0);
    chk("t1_result_idle", bus_e.result_o, 32'd0);

    // all-ones squared, full iteration count: 34 cycles, stall 33.
    run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, total, stall_n, got, first_busy, wb_stall, res, wbe, wba);
    chk("t2_done", {31'b0, got}, 32'd1);
    chk("t2_total", total, 32'd34);
    chk("t2_stall_cycles", stall_n, 32'd33);
    chk("t2_result", res, 32'h0000_0001);
    chk("t2_rf9", rf[9], 32'h0000_0001);
    chk("t2_idle_after", {31'b0, bus_f.busy_o}, 32'd0);

    // rs = 0, early exit: one CALC cycle, result 0 overwrites r10.
    run_mul(1'b0, 32'd0, 32'h1234, 5'd10, 1'b0, total, stall_n, got, first_busy, wb_stall, res, wbe, wba);
    chk("t3_total", total, 32'd3);
    chk("t3_result", res, 32'd0);
    chk("t3_rf10", rf[10], 32'd0);

    // rd = 0: done pulses, no write enable.
    run_mul(1'b0, 32'd7, 32'd6, 5'd0, 1'b0, total, stall_n, got, first_busy, wb_stall, res, wbe, wba);
    chk("t4_done", {31'b0, got}, 32'd1);
    chk("t4_total", total, 32'd5);
    chk("t4_wben", {31'b0, wbe}, 32'd0);
    chk("t4_rf0", rf[0], 32'd0);

    // Reset in CALC cycle 3 aborts with no writeback.
    use_f = 1'b0;
    rs = 32'd100;
    rt = 32'd100;
    rd = 5'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("t5_busy_calc3", {31'b0, bus_e.busy_o}, 32'd1);
    chk("t5_stall_calc3", {31'b0, bus_e.stall_o}, 32'd1);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #2;
    chk("t5_busy_rst", {31'b0, bus_e.busy_o}, 32'd0);
    chk("t5_stall_rst", {31'b0, bus_e.stall_o}, 32'd0);
    chk("t5_done_rst", {31'b0, bus_e.done_o}, 32'd0);
    chk("t5_wben_rst", {31'b0, bus_e.wb_en_o}, 32'd0);
    chk("t5_result_rst", bus_e.result_o, 32'd0);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #2;
      chk("t5_no_wb", {31'b0, bus_e.wb_en_o | bus_e.busy_o}, 32'd0);
    end
    chk("t5_rf4", rf[4], 32'hDEAD_0004);
    @(posedge clk);
    #1;

    // Back-to-back: 2 x 3 -> r1, then r1 x 4 -> r2 with no bubble.
    run_mul(1'b0, 32'd2, 32'd3, 5'd1, 1'b1, total, stall_n, got, first_busy, wb_stall, res, wbe, wba);
    chk("t6a_result", res, 32'd6);
    chk("t6a_rf1", rf[1], 32'd6);
    run_mul(1'b0, rf[1], 32'd4, 5'd2, 1'b0, total, stall_n, got, first_busy, wb_stall, res, wbe, wba);
    chk("t6b_first_busy", {31'b0, first_busy}, 32'd0);
    chk("t6b_done", {31'b0, got}, 32'd1);
    chk("t6b_result", res, 32'd24);
    chk("t6b_rf2", rf[2], 32'd24);
    chk("t6b_rf1_kept", rf[1], 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
